pos_move_ctrl: RTL and testbench
================================

// Module: pos_move_ctrl
// PURPOSE
//  Closed-loop "drive N counts" sequencer on the consumer side of the position counters.
//  - Clears the counters.
//  - Enables both motors and steers them straight using the signed count difference.
//  - Stops when the shorter wheel's distance reaches the target.
//  Drives the counter clear bus and the motor enable/direction lines; reports busy/done/fault.
// PARAMETERS
//  TOL          4       max |pos_diff| (counts) before the leading motor is paused
//  SETTLE_CYC   2       cycles waited after clear before distance is trusted (>=1)
//  BRAKE_CYC    1000    cycles enables held low after target reached
//  STALL_CYC    100000  cycles with neither count changing in RUN -> FAULT (0 = disabled)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   one-cycle request; honoured only in IDLE
//  abort        in   1   synchronous abort; any state -> IDLE
//  target       in   16  distance in sensor counts, latched on accepted start
//  dir          in   2   [0]=motor1 dir, [1]=motor2 dir, latched on accepted start
//  pos12        in   16  motor1 distance count
//  pos22        in   16  motor2 distance count
//  pos_diff     in   16  pos12-pos22, two's complement
//  clear        out  2   counter clear bus; bit0=clock counter, bit1=distance counters
//  m1_en        out  1   motor1 enable
//  m2_en        out  1   motor2 enable
//  m1_dir       out  1   motor1 direction
//  m2_dir       out  1   motor2 direction
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle pulse on successful completion
//  fault        out  1   high in FAULT; cleared on leaving FAULT
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, every output 0, latched target/dir 0, timers 0.
//  - States: IDLE, CLEAR, SETTLE, RUN, BRAKE, DONE, FAULT. All transitions on posedge clk.
//  - IDLE: start=1 & target!=0 -> CLEAR; latch target and dir.
//  - IDLE: start=1 & target==0 -> DONE; no clear issued, motors stay off.
//  - CLEAR: clear=2'b11 for exactly one cycle -> SETTLE. clear=2'b00 in all other states.
//  - SETTLE: wait SETTLE_CYC cycles, enables low -> RUN.
//  - RUN: dmin = min(pos12,pos22), unsigned. Each cycle, in priority order:
//    1. dmin >= target -> BRAKE; enables drop on the transition cycle.
//    2. stall timer reached STALL_CYC -> FAULT.
//    3. Otherwise steer on signed pos_diff:
//       pos_diff > +TOL -> m1_en=0, m2_en=1
//       pos_diff < -TOL -> m1_en=1, m2_en=0
//       else both enables 1.
//  - Stall timer: reset on RUN entry and on any cycle where pos12 or pos22 differs from the
//    previous cycle; saturates; ignored when STALL_CYC=0.
//  - m*_dir driven from latched dir during RUN and BRAKE; 0 elsewhere.
//  - BRAKE: enables 0 for BRAKE_CYC cycles -> DONE.
//  - DONE: done=1 for one cycle -> IDLE. busy is still 1 in DONE.
//  - FAULT: enables 0, fault=1. start -> CLEAR with the new target latched. abort -> IDLE.
//  - abort overrides start and all other transitions:
//    - next cycle: IDLE, enables 0, clear 2'b00, no done pulse.
//  - start outside IDLE/FAULT is ignored; it is not queued.
//  - Count wrap: counters do not exceed 16 bits; target up to 16'hFFFF is legal.
//  - Async reset mid-move: enables drop immediately, without waiting for a clock edge.
// TESTING
//  - target=10, counts ramp equally from 0:
//    -> clear=11 for 1 cycle, enables high after SETTLE_CYC;
//    -> enables low the cycle after dmin hits 10;
//    -> done pulses after BRAKE_CYC; busy low next cycle.
//  - RUN with pos12=20, pos22=10 (diff=+10, TOL=4) -> m1_en=0, m2_en=1.
//    - raise pos22 to 17 -> both enables 1;
//    - pos12=10, pos22=20 -> m1_en=1, m2_en=0.
//  - RUN with counts frozen, STALL_CYC=50:
//    -> FAULT at cycle 50, fault=1, enables 0;
//    -> start with target=5 -> CLEAR, fault=0.
//  - abort asserted mid-RUN together with start -> IDLE next cycle, enables 0, no done, busy=0.
//  - target=0 -> done pulse 1 cycle after start, clear never asserted, enables never high.
//  - rst_n low mid-RUN (between edges) -> enables and busy 0 immediately;
//    after release, state is IDLE.

Source files
------------

// File: rtl/pos_move_ctrl.sv
// Drive-N-counts sequencer: clears the position counters, runs both motors straight
// using the count difference, and brakes once the shorter wheel reaches the target.
module pos_move_ctrl #(
    parameter int TOL        = 4,
    parameter int SETTLE_CYC = 2,
    parameter int BRAKE_CYC  = 1000,
    parameter int STALL_CYC  = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] target,
    input  logic [1:0]  dir,
    input  logic [15:0] pos12,
    input  logic [15:0] pos22,
    input  logic [15:0] pos_diff,
    output logic [1:0]  clear,
    output logic        m1_en,
    output logic        m2_en,
    output logic        m1_dir,
    output logic        m2_dir,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    // state   | meaning
    // IDLE    | waiting for start
    // CLEAR   | counter clear bus asserted for one cycle
    // SETTLE  | counters settling after clear, motors off
    // RUN     | motors driven and steered until target or stall
    // BRAKE   | motors off for BRAKE_CYC cycles
    // DONE    | one-cycle completion pulse
    // FAULT   | stall detected, motors off until start or abort
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_BRAKE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam int MAX_SB  = (SETTLE_CYC > BRAKE_CYC) ? SETTLE_CYC : BRAKE_CYC;
    localparam int MAX_CYC = (MAX_SB > STALL_CYC) ? MAX_SB : STALL_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [TMR_W-1:0] BRAKE_LD  = TMR_W'((BRAKE_CYC > 0) ? BRAKE_CYC - 1 : 0);
    localparam logic [TMR_W-1:0] STALL_LD  = TMR_W'((STALL_CYC > 0) ? STALL_CYC - 1 : 0);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam bit               STALL_ON  = (STALL_CYC != 0);
    localparam logic signed [16:0] TOL_S   = 17'(TOL);

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [15:0]      tgt_q;
    logic [1:0]       dir_q;
    logic [15:0]      prev12_q, prev22_q;
    logic [15:0]      dmin;
    logic             moved;
    logic             accept;
    logic             steer_m1, steer_m2;
    logic signed [16:0] diff_s;

    assign dmin   = (pos12 < pos22) ? pos12 : pos22;
    assign moved  = (pos12 != prev12_q) || (pos22 != prev22_q);
    assign diff_s = {pos_diff[15], pos_diff};
    assign accept = start && !abort && ((state_q == S_IDLE) || (state_q == S_FAULT));

    always_comb begin
        steer_m1 = 1'b1;
        steer_m2 = 1'b1;
        if (diff_s > TOL_S) begin
            steer_m1 = 1'b0;
        end else if (diff_s < -TOL_S) begin
            steer_m2 = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = (target == 16'd0) ? S_DONE : S_CLEAR;
                end
                S_CLEAR: begin
                    state_d = S_SETTLE;
                    tmr_d   = SETTLE_LD;
                end
                S_SETTLE: begin
                    if (tmr_q == '0) begin
                        state_d = S_RUN;
                        tmr_d   = STALL_LD;
                    end else begin
                        tmr_d = tmr_q - TMR_ONE;
                    end
                end
                S_RUN: begin
                    if (dmin >= tgt_q) begin
                        state_d = S_BRAKE;
                        tmr_d   = BRAKE_LD;
                    end else if (moved) begin
                        tmr_d = STALL_LD;
                    end else if (STALL_ON && (tmr_q == '0)) begin
                        state_d = S_FAULT;
                    end else if (tmr_q != '0) begin
                        tmr_d = tmr_q - TMR_ONE;
                    end
                end
                S_BRAKE: begin
                    if (tmr_q == '0) state_d = S_DONE;
                    else             tmr_d   = tmr_q - TMR_ONE;
                end
                S_DONE:  state_d = S_IDLE;
                S_FAULT: begin
                    if (start) state_d = S_CLEAR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the state being entered so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            tgt_q    <= '0;
            dir_q    <= '0;
            prev12_q <= '0;
            prev22_q <= '0;
            clear    <= 2'b00;
            m1_en    <= 1'b0;
            m2_en    <= 1'b0;
            m1_dir   <= 1'b0;
            m2_dir   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            prev12_q <= pos12;
            prev22_q <= pos22;
            if (accept) begin
                tgt_q <= target;
                dir_q <= dir;
            end
            clear  <= (state_d == S_CLEAR) ? 2'b11 : 2'b00;
            m1_en  <= (state_d == S_RUN) && steer_m1;
            m2_en  <= (state_d == S_RUN) && steer_m2;
            m1_dir <= ((state_d == S_RUN) || (state_d == S_BRAKE)) && dir_q[0];
            m2_dir <= ((state_d == S_RUN) || (state_d == S_BRAKE)) && dir_q[1];
            busy   <= (state_d != S_IDLE);
            done   <= (state_d == S_DONE);
            fault  <= (state_d == S_FAULT);
        end
    end

endmodule

// File: tb/tb_pos_move_ctrl.sv
// Bench for pos_move_ctrl: directed scenarios with literal expectations, then
// randomized closed-loop moves against a phase-level reference model.
module tb_pos_move_ctrl;

    localparam int TOL        = 4;
    localparam int SETTLE_CYC = 2;
    localparam int BRAKE_CYC  = 20;
    localparam int STALL_CYC  = 50;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] target;
    logic [1:0]  dir;
    logic [15:0] pos12;
    logic [15:0] pos22;
    logic [15:0] pos_diff;
    logic [1:0]  clear;
    logic        m1_en, m2_en, m1_dir, m2_dir, busy, done, fault;

    pos_move_ctrl #(
        .TOL(TOL), .SETTLE_CYC(SETTLE_CYC), .BRAKE_CYC(BRAKE_CYC), .STALL_CYC(STALL_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target(target), .dir(dir),
        .pos12(pos12), .pos22(pos22), .pos_diff(pos_diff), .clear(clear),
        .m1_en(m1_en), .m2_en(m2_en), .m1_dir(m1_dir), .m2_dir(m2_dir),
        .busy(busy), .done(done), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {P_IDLE, P_CLEAR, P_SETTLE, P_RUN, P_BRAKE, P_DONE, P_FAULT} phase_t;

    phase_t      ph;
    logic [15:0] m_tgt;
    logic [1:0]  m_dir;
    logic [1:0]  m_steer;   // {m1_en, m2_en} while running
    int          m_cnt;
    int          m_frozen;
    logic [15:0] m_prev12, m_prev22;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        ph       = P_IDLE;
        m_tgt    = '0;
        m_dir    = '0;
        m_steer  = '0;
        m_cnt    = 0;
        m_frozen = 0;
        m_prev12 = '0;
        m_prev22 = '0;
    endtask

    function automatic logic [1:0] steer_rule(input logic [15:0] d);
        int sd;
        sd = int'($signed(d));
        if (sd > TOL)       return 2'b01;
        else if (sd < -TOL) return 2'b10;
        else                return 2'b11;
    endfunction

    task automatic model_step();
        bit          same;
        logic [15:0] dmin;
        if (!rst_n) begin
            m_reset();
            return;
        end
        same = (pos12 == m_prev12) && (pos22 == m_prev22);
        dmin = (pos12 < pos22) ? pos12 : pos22;
        if (abort) begin
            ph = P_IDLE;
        end else begin
            case (ph)
                P_IDLE: if (start) begin
                    m_tgt = target;
                    m_dir = dir;
                    ph    = (target == 16'd0) ? P_DONE : P_CLEAR;
                end
                P_CLEAR: begin
                    ph    = P_SETTLE;
                    m_cnt = 0;
                end
                P_SETTLE: begin
                    m_cnt++;
                    if (m_cnt == SETTLE_CYC) begin
                        ph       = P_RUN;
                        m_frozen = 0;
                        m_steer  = steer_rule(pos_diff);
                    end
                end
                P_RUN: begin
                    if (dmin >= m_tgt) begin
                        ph    = P_BRAKE;
                        m_cnt = 0;
                    end else begin
                        m_frozen = same ? m_frozen + 1 : 0;
                        if (STALL_CYC != 0 && m_frozen >= STALL_CYC) ph = P_FAULT;
                        else m_steer = steer_rule(pos_diff);
                    end
                end
                P_BRAKE: begin
                    m_cnt++;
                    if (m_cnt == BRAKE_CYC) ph = P_DONE;
                end
                P_DONE: ph = P_IDLE;
                P_FAULT: if (start) begin
                    m_tgt = target;
                    m_dir = dir;
                    ph    = P_CLEAR;
                end
                default: ph = P_IDLE;
            endcase
        end
        m_prev12 = pos12;
        m_prev22 = pos22;
    endtask

    function automatic logic [8:0] exp_vec();
        logic [1:0] e_en, e_dir;
        e_en  = (ph == P_RUN) ? m_steer : 2'b00;
        e_dir = (ph == P_RUN || ph == P_BRAKE) ? {m_dir[0], m_dir[1]} : 2'b00;
        return {((ph == P_CLEAR) ? 2'b11 : 2'b00), e_en, e_dir,
                (ph != P_IDLE), (ph == P_DONE), (ph == P_FAULT)};
    endfunction

    task automatic compare_all();
        logic [8:0] act, exp;
        act = {clear, m1_en, m2_en, m1_dir, m2_dir, busy, done, fault};
        exp = exp_vec();
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL outputs at %0t: got clr/en/dir/busy/done/fault=%b, expected %b",
                     $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_pos(input logic [15:0] p1, input logic [15:0] p2);
        pos12    = p1;
        pos22    = p2;
        pos_diff = p1 - p2;
    endtask

    task automatic go(input logic [15:0] t, input logic [1:0] d);
        start  = 1'b1;
        target = t;
        dir    = d;
        cyc();
        start  = 1'b0;
        set_pos(16'd0, 16'd0);
    endtask

    int  hits;
    bit  freeze;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        target = '0;
        dir    = '0;
        set_pos(16'd0, 16'd0);
        m_reset();
        cyc();
        cyc();
        chk("reset_outputs", {clear, m1_en, m2_en, m1_dir, m2_dir, busy, done, fault}, 9'd0);
        rst_n = 1'b1;
        cyc();

        // target=10 with counts ramping together
        go(16'd10, 2'b01);
        chk("start_clear", clear, 2'b11);
        chk("start_busy", busy, 1'b1);
        cyc();
        chk("settle_clear", clear, 2'b00);
        chk("settle_en", {m1_en, m2_en}, 2'b00);
        cyc();
        chk("settle2_en", {m1_en, m2_en}, 2'b00);
        cyc();
        chk("run_en", {m1_en, m2_en}, 2'b11);
        chk("run_dir", {m1_dir, m2_dir}, 2'b10);
        for (int i = 1; i <= 10; i++) begin
            set_pos(16'(i), 16'(i));
            cyc();
            chk("ramp_en", {m1_en, m2_en}, (i < 10) ? 2'b11 : 2'b00);
        end
        hits = 0;
        for (int i = 1; i < BRAKE_CYC; i++) begin
            cyc();
            if (done) hits++;
        end
        chk("brake_no_done", hits, 0);
        cyc();
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b1);
        cyc();
        chk("after_done", {busy, done}, 2'b00);

        // steering
        go(16'd1000, 2'b10);
        cyc(); cyc(); cyc();
        set_pos(16'd20, 16'd10);
        cyc();
        chk("steer_pos", {m1_en, m2_en}, 2'b01);
        chk("steer_dir", {m1_dir, m2_dir}, 2'b01);
        set_pos(16'd20, 16'd17);
        cyc();
        chk("steer_mid", {m1_en, m2_en}, 2'b11);
        set_pos(16'd10, 16'd20);
        cyc();
        chk("steer_neg", {m1_en, m2_en}, 2'b10);

        // stall with frozen counts
        hits = 0;
        for (int i = 1; i < STALL_CYC; i++) begin
            cyc();
            if (fault) hits++;
        end
        chk("no_early_fault", hits, 0);
        cyc();
        chk("stall_fault", fault, 1'b1);
        chk("stall_en", {m1_en, m2_en}, 2'b00);
        go(16'd5, 2'b11);
        chk("fault_restart_clear", clear, 2'b11);
        chk("fault_cleared", fault, 1'b0);

        // abort together with start mid-run
        cyc(); cyc(); cyc();
        set_pos(16'd1, 16'd1);
        start  = 1'b1;
        abort  = 1'b1;
        target = 16'd7;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_state", {clear, m1_en, m2_en, busy, done}, 6'd0);
        cyc();
        chk("abort_no_done", done, 1'b0);

        // zero target
        go(16'd0, 2'b11);
        chk("zero_done", done, 1'b1);
        chk("zero_clear", clear, 2'b00);
        chk("zero_en", {m1_en, m2_en}, 2'b00);
        cyc();
        chk("zero_idle", {busy, done}, 2'b00);

        // full-range target
        go(16'hFFFF, 2'b00);
        cyc(); cyc(); cyc();
        set_pos(16'hFFFF, 16'hFFFE);
        cyc();
        chk("wrap_not_reached", {m1_en, m2_en}, 2'b11);
        set_pos(16'hFFFF, 16'hFFFF);
        cyc();
        chk("wrap_reached", {m1_en, m2_en, busy}, 3'b001);
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        // async reset mid-run
        go(16'd1000, 2'b11);
        cyc(); cyc(); cyc();
        chk("pre_reset_en", {m1_en, m2_en}, 2'b11);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", {m1_en, m2_en, busy}, 3'b000);
        m_reset();
        cyc();
        rst_n = 1'b1;
        set_pos(16'd0, 16'd0);
        cyc();
        chk("post_reset_idle", busy, 1'b0);

        // randomized closed-loop moves
        freeze = 1'b0;
        for (int n = 0; n < 8000; n++) begin
            start = 1'b0;
            abort = 1'b0;
            if (ph == P_CLEAR) begin
                set_pos(16'd0, 16'd0);
            end else begin
                if (!freeze && ph == P_RUN) begin
                    if (m_steer[1] && ($urandom % 4 != 0)) pos12 = pos12 + 16'd1;
                    if (m_steer[0] && ($urandom % 4 != 0)) pos22 = pos22 + 16'd1;
                end
                if ($urandom % 40 == 0) pos12 = pos12 + 16'($urandom % 12);
                set_pos(pos12, pos22);
            end
            if ($urandom % 25 == 0) begin
                start  = 1'b1;
                target = ($urandom % 10 == 0) ? 16'd0 : 16'($urandom_range(1, 60));
                dir    = 2'($urandom);
            end
            if ($urandom % 300 == 0) abort = 1'b1;
            if ($urandom % 150 == 0) freeze = !freeze;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
